// File: rtl/mskand_hpc_sched.sv
// ---------------------------------------------------------------------------
// mskand_hpc_sched
//
// Shares one pipelined HPC masked-AND gadget between two masked datapaths.
// Each cycle it picks at most one requester, takes one fresh randomness word
// from the PRNG, and skews the operands to the gadget's per-input latencies:
// randomness at issue (t), B at t+2, A at t+3. The result comes back at t+4
// and is routed to the requester that issued it. Fully pipelined: one issue
// per cycle, up to four operations in flight, and no result backpressure.
//
// Shares are never combined. Every register and mux works per share, and no
// logic spans share indices.
//
// Configuration macro:
//   MSKAND_SCHED_RR_EN  defined   -> round-robin arbitration with a 1-bit
//                                    pointer. When both requesters ask, the
//                                    pointer's requester wins. After each
//                                    issue the pointer moves to the requester
//                                    that was not granted.
//                       undefined -> fixed priority: requester 0 always wins.
//
// Parameters:
//   d     masking order (shares per sharing)
//   NRND  gadget randomness width
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   req_valid    [2]      request valid, bit k = requester k
//   req_ready    [2]      request accepted this cycle (combinational grant)
//   req_a/req_b  [2*d]    operand sharings, requester k at [k*d +: d]
//   rnd_in       [NRND]   fresh randomness from the PRNG
//   rnd_ok                rnd_in is fresh
//   rnd_ack               rnd_in consumed this cycle
//   g_rnd        [NRND]   to gadget rnd (zero unless issuing)
//   g_inb, g_ina [d]      to gadget inb / ina (zero when idle)
//   g_out        [d]      from gadget out
//   rsp_valid    [2]      one-cycle result pulse for requester k
//   rsp_data     [d]      result sharing (zero when no result is valid)
//   busy                  at least one operation in flight
// ---------------------------------------------------------------------------
module mskand_hpc_sched #(
  parameter int d    = 2,
  parameter int NRND = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*d-1:0]  req_a,
  input  logic [2*d-1:0]  req_b,
  input  logic [NRND-1:0] rnd_in,
  input  logic            rnd_ok,
  output logic            rnd_ack,
  output logic [NRND-1:0] g_rnd,
  output logic [d-1:0]    g_inb,
  output logic [d-1:0]    g_ina,
  input  logic [d-1:0]    g_out,
  output logic [1:0]      rsp_valid,
  output logic [d-1:0]    rsp_data,
  output logic            busy
);

  logic         issue;
  logic         gid;    // requester selected this cycle (meaningful only on issue)
  logic [d-1:0] sel_a;
  logic [d-1:0] sel_b;

  // B: 2 stages, A: 3 stages, tag {valid, id}: 4 stages.
  logic [d-1:0] b_q [2];
  logic [1:0]   b_v;
  logic [d-1:0] a_q [3];
  logic [2:0]   a_v;
  logic [3:0]   t_v;
  logic [3:0]   t_id;

`ifdef MSKAND_SCHED_RR_EN
  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (issue) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every flop samples the pre-edge values regardless of block order.
      ptr <= ~gid;
    end
  end
`endif

  // Grant. Reset gates the request so the handshake outputs drop
  // asynchronously together with the pipeline.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    req_ready = 2'b00;
    gid       = 1'b0;
`ifdef MSKAND_SCHED_RR_EN
    gid = (req_valid == 2'b11) ? ptr : req_valid[1];
`else
    gid = ~req_valid[0];
`endif
    if (!rst && rnd_ok && (|req_valid)) begin
      req_ready[gid] = 1'b1;
    end
  end

  assign issue   = |req_ready;
  assign rnd_ack = issue;
  assign g_rnd   = rnd_in & {NRND{issue}};

  // Per-share operand select. A whole d-bit sharing is chosen at once, and
  // share i only ever comes from share i of a requester.
  assign sel_a = gid ? req_a[d +: d] : req_a[0 +: d];
  assign sel_b = gid ? req_b[d +: d] : req_b[0 +: d];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand stages are reset along with their valid bits. After
      // reset the gadget must see all-zero sharings, not stale share values.
      b_q  <= '{default: '0};
      a_q  <= '{default: '0};
      b_v  <= '0;
      a_v  <= '0;
      t_v  <= '0;
      t_id <= '0;
    end else begin
      // The first stage loads zero when nothing issues, so idle cycles carry
      // no share data through the pipeline.
      b_q[0] <= issue ? sel_b : '0;
      b_q[1] <= b_q[0];
      b_v    <= {b_v[0], issue};

      a_q[0] <= issue ? sel_a : '0;
      a_q[1] <= a_q[0];
      a_q[2] <= a_q[1];
      a_v    <= {a_v[1:0], issue};

      t_v    <= {t_v[2:0], issue};
      t_id   <= {t_id[2:0], issue & gid};
    end
  end

  assign g_inb = b_q[1] & {d{b_v[1]}};
  assign g_ina = a_q[2] & {d{a_v[2]}};

  assign rsp_valid = {t_v[3] & t_id[3], t_v[3] & ~t_id[3]};
  assign rsp_data  = g_out & {d{t_v[3]}};
  assign busy      = |t_v;

endmodule

// File: tb/tb_mskand_hpc_sched.sv
// ---------------------------------------------------------------------------
// tb_mskand_hpc_sched
//
// Drives mskand_hpc_sched (d=2, NRND=2) with directed and random traffic and
// compares every output each cycle against a reference model. The model keeps
// per-cycle expectation arrays: an issue in cycle t schedules B at t+2, A at
// t+3 and a tagged result at t+4.
//
// A small behavioural gadget drives g_out. It registers the result of
// ina(t+3), inb(t+2) and rnd(t) into cycle t+4, so a wrong operand skew in the
// scheduler changes the returned data.
//
// Arbitration follows MSKAND_SCHED_RR_EN in the same way as the DUT.
// ---------------------------------------------------------------------------
module tb_mskand_hpc_sched;

  localparam int D    = 2;
  localparam int NRND = 2;
  localparam int NCYC = 4096;

`ifdef MSKAND_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*D-1:0]  req_a;
  logic [2*D-1:0]  req_b;
  logic [NRND-1:0] rnd_in;
  logic            rnd_ok;
  logic            rnd_ack;
  logic [NRND-1:0] g_rnd;
  logic [D-1:0]    g_inb;
  logic [D-1:0]    g_ina;
  logic [D-1:0]    g_out;
  logic [1:0]      rsp_valid;
  logic [D-1:0]    rsp_data;
  logic            busy;

  mskand_hpc_sched #(.d(D), .NRND(NRND)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rnd_in    (rnd_in),
    .rnd_ok    (rnd_ok),
    .rnd_ack   (rnd_ack),
    .g_rnd     (g_rnd),
    .g_inb     (g_inb),
    .g_ina     (g_ina),
    .g_out     (g_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Masked AND: out0 ^ out1 == (a0 ^ a1) & (b0 ^ b1).
  function automatic logic [1:0] gfun(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] r);
    logic [1:0] o;
    o[0] = (a[0] & b[0]) ^ (a[0] & b[1]) ^ r[0] ^ r[1];
    o[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ r[0] ^ r[1];
    return o;
  endfunction

  // Behavioural gadget with the per-input latencies of the shared gadget.
  logic [1:0] inb_d1, rnd_d1, rnd_d2, rnd_d3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inb_d1 <= '0;
      rnd_d1 <= '0;
      rnd_d2 <= '0;
      rnd_d3 <= '0;
      g_out  <= '0;
    end else begin
      inb_d1 <= g_inb;
      rnd_d1 <= g_rnd;
      rnd_d2 <= rnd_d1;
      rnd_d3 <= rnd_d2;
      g_out  <= gfun(g_ina, inb_d1, rnd_d3);
    end
  end

  // Reference model state
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  bit         rr_ptr = 1'b0;
  logic [1:0] e_inb [NCYC];
  logic [1:0] e_ina [NCYC];
  logic [1:0] e_rv  [NCYC];
  logic [1:0] e_rd  [NCYC];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] rv);
    if (rv == 2'b11) return RR ? int'(rr_ptr) : 0;
    return rv[1] ? 1 : 0;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check settled outputs
  // 2 time units later, then record what this cycle's issue must produce.
  task automatic step(input logic [1:0] rv, input logic [3:0] a,
                      input logic [3:0] b, input logic [1:0] rnd,
                      input logic ok, input logic r);
    int         g;
    logic [1:0] e_ready;
    logic [1:0] ga;
    logic [1:0] gb;
    @(negedge clk);
    rst = r; req_valid = rv; req_a = a; req_b = b; rnd_in = rnd; rnd_ok = ok;
    #2;
    if (r) begin
      for (int i = 0; i < 5; i++) begin
        e_inb[cyc+i] = '0; e_ina[cyc+i] = '0; e_rv[cyc+i] = '0; e_rd[cyc+i] = '0;
      end
      rr_ptr = 1'b0;
    end
    g = (!r && ok && rv != 2'b00) ? pick(rv) : -1;
    e_ready = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
    check("req_ready", req_ready, e_ready);
    check("rnd_ack",   rnd_ack,   g >= 0);
    check("g_rnd",     g_rnd,     (g >= 0) ? rnd : 2'b00);
    check("g_inb",     g_inb,     e_inb[cyc]);
    check("g_ina",     g_ina,     e_ina[cyc]);
    check("rsp_valid", rsp_valid, e_rv[cyc]);
    check("rsp_data",  rsp_data,  e_rd[cyc]);
    check("busy",      busy, (e_rv[cyc] | e_rv[cyc+1] | e_rv[cyc+2] | e_rv[cyc+3]) != 0);
    if (g >= 0) begin
      ga = (g == 0) ? a[1:0] : a[3:2];
      gb = (g == 0) ? b[1:0] : b[3:2];
      e_inb[cyc+2] = gb;
      e_ina[cyc+3] = ga;
      e_rv[cyc+4]  = e_ready;
      e_rd[cyc+4]  = gfun(ga, gb, rnd);
      rr_ptr       = (g == 0);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      e_inb[i] = '0; e_ina[i] = '0; e_rv[i] = '0; e_rd[i] = '0;
    end

    // Reset state while requests and randomness are being offered
    rst = 1'b1; req_valid = 2'b11; req_a = 4'hF; req_b = 4'hF;
    rnd_in = 2'b11; rnd_ok = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rnd_ack",   rnd_ack,   1'b0);
    check("rst_g_rnd",     g_rnd,     2'b00);
    check("rst_busy",      busy,      1'b0);
    step(2'b11, 4'hF, 4'hF, 2'b11, 1'b1, 1'b1);
    step(2'b11, 4'hF, 4'hF, 2'b11, 1'b1, 1'b1);
    cyc = 0;

    // Single issue from requester 0 in cycle 5: A=10, B=11, rnd=01
    idle(5);
    step(2'b01, 4'b0010, 4'b0011, 2'b01, 1'b1, 1'b0);
    idle(5);

    // Both requesters hold valid for 4 cycles, then only requester 1
    for (int i = 0; i < 4; i++)
      step(2'b11, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b0);
    step(2'b10, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b0);
    step(2'b10, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b0);
    idle(5);

    // Randomness stalls for 3 cycles with operations still in flight
    step(2'b11, 4'h6, 4'h9, 2'b10, 1'b1, 1'b0);
    step(2'b11, 4'h5, 4'hA, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b11, 4'hC, 4'h3, 2'b11, 1'b0, 1'b0);
    step(2'b11, 4'h3, 4'hC, 2'b10, 1'b1, 1'b0);
    idle(5);

    // Asynchronous reset two cycles after an issue
    step(2'b01, 4'hE, 4'h7, 2'b11, 1'b1, 1'b0);
    step(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
    step(2'b11, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("arst_req_ready", req_ready, 2'b00);
    check("arst_rnd_ack",   rnd_ack,   1'b0);
    check("arst_g_rnd",     g_rnd,     2'b00);
    check("arst_g_inb",     g_inb,     2'b00);
    check("arst_g_ina",     g_ina,     2'b00);
    check("arst_rsp_valid", rsp_valid, 2'b00);
    check("arst_rsp_data",  rsp_data,  2'b00);
    check("arst_busy",      busy,      1'b0);
    step(2'b11, 4'hF, 4'hF, 2'b11, 1'b1, 1'b1);
    step(2'b00, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1);

    // Idle for 10 cycles: no responses from the discarded operations
    idle(10);

    // Random traffic with random stalls and occasional resets
    for (int i = 0; i < 1500; i++)
      step(2'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
           ($urandom_range(3) != 0), ($urandom_range(199) == 0));
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
